fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  single clock; all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 pc_write  in  1  from hazard unit; 0 freezes PC and blocks new fetch issue.
REQ-004 ifid_write  in  1  from hazard unit; 0 holds IF/ID register contents.
REQ-005 redirect_valid  in  1  taken branch/jump from EX; flush request.
REQ-006 redirect_pc  in  16  redirect target, word address.
REQ-007 imem_req  out  1  instruction-memory read request, one word per cycle.
REQ-008 imem_addr  out  16  read address, equal to the current PC.
REQ-009 imem_rvalid  in  1  response strobe; always exactly one cycle after the accepted imem_req.
REQ-010 imem_rdata  in  16  instruction word, valid with imem_rvalid.
REQ-011 ifid_valid  out  1  IF/ID holds a real instruction.
REQ-012 ifid_instr  out  16  IF/ID instruction.
REQ-013 ifid_pc  out  16  IF/ID instruction address.
REQ-014 ifid_rd, ifid_rs1, ifid_rs2  out  4 each  fields instr[11:8], [7:4], [3:0]; forced to 0 when ifid_valid=0.

Function
REQ-015 PC: 16-bit word address; increments by 1 per issued fetch; 0xFFFF wraps to 0x0000.
REQ-016 Issue: imem_req=1 iff rst=0, pc_write=1, redirect_valid=0, and (buffer count + in-flight) < 2; imem_addr=PC during issue.
REQ-017 In-flight: one flag plus an epoch bit per request; a response pushes {pc, instr} into a 2-entry buffer only if its epoch matches the current epoch.
REQ-018 IF/ID update when ifid_write=1: load buffer head (pop); if buffer empty but a matching response arrives this cycle, load it directly (bypass); otherwise load a bubble (ifid_valid=0).
REQ-019 ifid_write=0: IF/ID holds all fields; buffer does not pop; pushes still accepted (occupancy rule guarantees space).
REQ-020 Latency: request in cycle N -> ifid_valid=1 with that instruction in cycle N+2 when buffer empty and ifid_write=1 in N+1.
REQ-021 Steady state with no stalls: one instruction per cycle into IF/ID, sequential PCs.
REQ-022 Redirect (priority over pc_write=0 and ifid_write=0): PC<=redirect_pc, buffer cleared, epoch toggled (in-flight response discarded), ifid_valid<=0, no issue that cycle; first fetch of redirect_pc issues next cycle.
REQ-023 Simultaneous stall release and response: push and pop in the same cycle leave occupancy unchanged.
REQ-024 Buffer never overflows nor underflows; overflow condition is unreachable by REQ-016.
REQ-025 Bubble output fields rs1/rs2/rd=0 so the hazard unit's r0 exclusion never stalls on a bubble.

Reset
REQ-026 On rst assertion, asynchronously: PC=PC_RESET (0x0000), buffer empty, in-flight=0, epoch=0, ifid_valid=0, ifid_instr=0, ifid_pc=0, imem_req=0.
REQ-027 Reset mid-operation drops any in-flight response; a response arriving the cycle after deassertion is ignored.
REQ-028 First imem_req issues in the first clock cycle after rst deasserts, address 0x0000.

Structure
REQ-029 Shared package cpu_pkg holds INSTR_W=16, PC_W=16, REG_ADDR_W=4, PC_RESET, field bit positions, NOP encoding.
REQ-030 The 2-entry {pc, instr} queue with push/pop/clear/count is sub-module fetch_buffer; PC, issue, epoch and IF/ID register live in fetch_stage.

Verification
REQ-031 Reset release, no stalls, rdata=0x1234,0x2345,... -> imem_addr 0x0000,0x0001,...; ifid_valid=1 two cycles after first req, ifid_pc 0x0000,0x0001 consecutively.
REQ-032 ifid_write=0 and pc_write=0 held 3 cycles during streaming -> IF/ID constant, at most 2 words buffered, no lost or duplicated PC after release.
REQ-033 redirect_valid=1, redirect_pc=0x0040 with a response in flight -> ifid_valid=0 next cycle, stale word discarded, next imem_addr=0x0040, next valid ifid_pc=0x0040.
REQ-034 Redirect asserted together with ifid_write=0 -> flush still occurs; ifid_valid=0.
REQ-035 redirect_pc=0xFFFF, free run -> fetch addresses 0xFFFF then 0x0000.
REQ-036 rst asserted mid-stream with buffer full -> all outputs zero immediately; after release, first fetch at 0x0000 and the stale response is not delivered.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU widths, reset PC, instruction field positions and NOP encoding.
package cpu_pkg;
  localparam int INSTR_W    = 16;
  localparam int PC_W       = 16;
  localparam int REG_ADDR_W = 4;

  localparam logic [PC_W-1:0]    PC_RESET  = 16'h0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [REG_ADDR_W-1:0] reg_field(input logic [INSTR_W-1:0] instr,
                                                      input int lsb);
    return instr[lsb +: REG_ADDR_W];
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs between the memory response and IF/ID.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t entry_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) entry_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clear) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        entry_q[wr_ptr_q] <= push_data;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign head  = entry_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, request issue with epoch-tagged in-flight tracking,
// a 2-deep fetch buffer and the IF/ID pipeline register.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_write,
  input  logic                  ifid_write,
  input  logic                  redirect_valid,
  input  logic [PC_W-1:0]       redirect_pc,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_rvalid,
  input  logic [INSTR_W-1:0]    imem_rdata,
  output logic                  ifid_valid,
  output logic [INSTR_W-1:0]    ifid_instr,
  output logic [PC_W-1:0]       ifid_pc,
  output logic [REG_ADDR_W-1:0] ifid_rd,
  output logic [REG_ADDR_W-1:0] ifid_rs1,
  output logic [REG_ADDR_W-1:0] ifid_rs2
);
  localparam logic [PC_W-1:0] PC_ONE = 1;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] inflight_pc_q;
  logic            inflight_q;
  logic            inflight_epoch_q;
  logic            epoch_q;
  fetch_entry_t    ifid_q;
  logic            ifid_valid_q;

  fetch_entry_t    buf_head;
  fetch_entry_t    resp_entry;
  logic [1:0]      buf_count;
  logic [1:0]      occupancy;
  logic            buf_empty;
  logic            issue;
  logic            resp_ok;
  logic            bypass;
  logic            buf_push;
  logic            buf_pop;

  // Memory handshake: imem_req is a one-cycle request that is always accepted;
  // imem_rvalid/imem_rdata answer it exactly one cycle later. Issue is gated so
  // buffered plus in-flight words never exceed the two buffer slots.
  assign occupancy  = buf_count + 2'(inflight_q);
  assign buf_empty  = (buf_count == 2'd0);
  assign issue      = !rst && pc_write && !redirect_valid && (occupancy < 2'd2);
  assign resp_ok    = imem_rvalid && inflight_q && (inflight_epoch_q == epoch_q);
  assign bypass     = ifid_write && buf_empty && resp_ok;
  assign buf_push   = resp_ok && !redirect_valid && !bypass;
  assign buf_pop    = ifid_write && !buf_empty && !redirect_valid;
  assign resp_entry = '{pc: inflight_pc_q, instr: imem_rdata};

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  fetch_buffer u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data (resp_entry),
    .pop       (buf_pop),
    .clear     (redirect_valid),
    .head      (buf_head),
    .count     (buf_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q             <= PC_RESET;
      inflight_pc_q    <= '0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else if (redirect_valid) begin
      // Toggling the epoch orphans any response still owed to the old path.
      pc_q       <= redirect_pc;
      epoch_q    <= ~epoch_q;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q             <= pc_q + PC_ONE;
        inflight_pc_q    <= pc_q;
        inflight_epoch_q <= epoch_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_q       <= '0;
      ifid_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      ifid_q       <= '{pc: '0, instr: NOP_INSTR};
      ifid_valid_q <= 1'b0;
    end else if (ifid_write) begin
      if (!buf_empty) begin
        ifid_q       <= buf_head;
        ifid_valid_q <= 1'b1;
      end else if (resp_ok) begin
        ifid_q       <= resp_entry;
        ifid_valid_q <= 1'b1;
      end else begin
        ifid_q       <= '{pc: '0, instr: NOP_INSTR};
        ifid_valid_q <= 1'b0;
      end
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_q.instr;
  assign ifid_pc    = ifid_q.pc;
  // Bubbles present r0 on every register field so hazard checks ignore them.
  assign ifid_rd  = ifid_valid_q ? reg_field(ifid_q.instr, RD_LSB)  : '0;
  assign ifid_rs1 = ifid_valid_q ? reg_field(ifid_q.instr, RS1_LSB) : '0;
  assign ifid_rs2 = ifid_valid_q ? reg_field(ifid_q.instr, RS2_LSB) : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responder, scripted stimulus and an
// in-order scoreboard of expected IF/ID deliveries.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        ifid_write;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        ifid_valid;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [3:0]  ifid_rd;
  logic [3:0]  ifid_rs1;
  logic [3:0]  ifid_rs2;

  logic        inject;
  logic        ld_q;
  logic [31:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_rd        (ifid_rd),
    .ifid_rs1       (ifid_rs1),
    .ifid_rs2       (ifid_rs2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h1234 + a * 16'h1111;
  endfunction

  always @(posedge clk) begin
    imem_rvalid <= imem_req || inject;
    imem_rdata  <= imem_req ? mem_word(imem_addr) : 16'hDEAD;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_pc(input logic [15:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  always @(posedge clk) ld_q <= ifid_write;

  // Monitor: a valid IF/ID word newly loaded on the last edge must be the next expected one.
  always @(negedge clk) begin
    if (ifid_valid === 1'b1 && ld_q === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", {ifid_pc, ifid_instr}, 32'hxxxxxxxx);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("ifid_pc_instr", {ifid_pc, ifid_instr}, e);
        chk("ifid_fields", {20'd0, ifid_rd, ifid_rs1, ifid_rs2}, {20'd0, e[11:0]});
      end
    end else if (ifid_valid === 1'b0) begin
      chk("bubble_fields", {20'd0, ifid_rd, ifid_rs1, ifid_rs2}, 32'd0);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rst_i, input logic pw_i, input logic iw_i,
                      input logic rd_i, input logic [15:0] rpc_i, input logic inj_i);
    @(posedge clk);
    #1;
    rst            = rst_i;
    pc_write       = pw_i;
    ifid_write     = iw_i;
    redirect_valid = rd_i;
    redirect_pc    = rpc_i;
    inject         = inj_i;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic pw_i, input logic iw_i);
    for (int i = 0; i < n; i++) step(1'b0, pw_i, iw_i, 1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; pc_write = 1'b1; ifid_write = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 16'h0000; inject = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("reset_state", {ifid_valid, imem_req, ifid_pc, ifid_instr},
        {1'b0, 1'b0, 16'h0000, 16'h0000});
    chk("reset_addr", {16'd0, imem_addr}, 32'h0000_0000);

    // Free run then stall: every PC 0..9 must appear exactly once.
    for (int a = 0; a < 10; a++) expect_pc(16'(a));
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("first_req", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0000});
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("second_addr", {16'd0, imem_addr}, 32'h0000_0001);
    chk("no_valid_at_n1", {31'd0, ifid_valid}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("valid_at_n2", {15'd0, ifid_valid, ifid_pc}, {15'd0, 1'b1, 16'h0000});
    run(3, 1'b1, 1'b1);
    run(3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("buffer_full_no_req_a", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("buffer_full_no_req_b", {31'd0, imem_req}, 32'd0);
    run(5, 1'b1, 1'b1);

    // Redirect with a response in flight.
    for (int a = 'h40; a < 'h43; a++) expect_pc(16'(a));
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0040, 1'b0);
    chk("redirect_no_issue", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("redirect_bubble", {31'd0, ifid_valid}, 32'd0);
    chk("redirect_addr", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0040});
    run(3, 1'b1, 1'b1);

    // Redirect while IF/ID is held.
    for (int a = 'h80; a < 'h83; a++) expect_pc(16'(a));
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0080, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("redirect_hold_bubble", {31'd0, ifid_valid}, 32'd0);
    chk("redirect_hold_addr", {16'd0, imem_addr}, 32'h0000_0080);
    run(3, 1'b1, 1'b1);

    // PC wrap.
    expect_pc(16'hFFFF);
    expect_pc(16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("wrap_addr_ffff", {16'd0, imem_addr}, 32'h0000_FFFF);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("wrap_addr_0000", {16'd0, imem_addr}, 32'h0000_0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);

    // Reset with buffer occupied and a response in flight, plus a stray strobe after release.
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("midreset_outputs", {ifid_valid, imem_req, ifid_pc, ifid_instr},
        {1'b0, 1'b0, 16'h0000, 16'h0000});
    chk("midreset_fields", {20'd0, ifid_rd, ifid_rs1, ifid_rs2}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
    for (int a = 0; a < 4; a++) expect_pc(16'(a));
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    chk("post_reset_req", {15'd0, imem_req, imem_addr}, {15'd0, 1'b1, 16'h0000});
    run(3, 1'b1, 1'b1);
    run(4, 1'b0, 1'b1);

    chk("all_delivered", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
